instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, 4, prefetch FIFO entries (power of two, 2..8).
REQ-003 CK_REF  in  1  clock, all state on rising edge.
REQ-004 int_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 HALT  in  1  freezes all state when high (no new request, no pop, PC held).
REQ-006 REDIRECT  in  1  branch/jump redirect strobe from decode.
REQ-007 REDIRECT_PC  in  32  redirect target address.
REQ-008 IMEM_REQ  out  1  instruction memory read request.
REQ-009 IMEM_ADDR  out  32  instruction memory word address.
REQ-010 IMEM_ACK  in  1  memory response valid; IMEM_RDATA valid this cycle.
REQ-011 IMEM_RDATA  in  32  fetched instruction word.
REQ-012 INST_VALID  out  1  FIFO head holds a valid instruction.
REQ-013 INST_READY  in  1  decode accepts head instruction.
REQ-014 INST_OUT  out  32  head instruction word.
REQ-015 INST_PC_OUT  out  32  address of head instruction.
REQ-016 FIFO_LEVEL  out  4  number of occupied FIFO entries.

Function
REQ-017 States IDLE, WAIT_ACK, DISCARD; at most one request outstanding.
REQ-018 IDLE -> WAIT_ACK when !HALT && !REDIRECT && (FIFO_LEVEL < DEPTH); IMEM_REQ high one cycle with IMEM_ADDR = fetch_pc.
REQ-019 WAIT_ACK: IMEM_REQ low, IMEM_ADDR held; on IMEM_ACK push {IMEM_RDATA, fetch_pc}, fetch_pc += 4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0), -> IDLE.
REQ-020 Slot reservation: request issued only when level plus outstanding < DEPTH, so an ACK never hits a full FIFO.
REQ-021 Pop when INST_VALID && INST_READY && !HALT; push and pop in same cycle leave level unchanged.
REQ-022 REDIRECT (any state, ignores HALT): FIFO emptied, fetch_pc <= {REDIRECT_PC[31:2], 2'b00}, effective next cycle; INST_VALID low next cycle.
REQ-023 REDIRECT in WAIT_ACK without IMEM_ACK -> DISCARD; DISCARD drops next IMEM_ACK data, then -> IDLE.
REQ-024 REDIRECT coincident with IMEM_ACK: ack data dropped, -> IDLE.
REQ-025 REDIRECT in DISCARD stays DISCARD, updates fetch_pc only.
REQ-026 IMEM_ACK in IDLE ignored (no push).
REQ-027 HALT high: IMEM_ACK in WAIT_ACK still captured (memory not stallable); no new request, no pop.
REQ-028 Pop of empty FIFO never occurs; INST_OUT/INST_PC_OUT undefined-but-stable when INST_VALID low.
REQ-029 First-word latency: IMEM_REQ in cycle 1 after reset release, INST_VALID the cycle after IMEM_ACK.

Reset
REQ-030 On int_rst_n low: state IDLE, fetch_pc = RESET_PC, FIFO empty, IMEM_REQ 0, IMEM_ADDR RESET_PC, INST_VALID 0, INST_OUT 0, INST_PC_OUT 0, FIFO_LEVEL 0.
REQ-031 Reset asserted mid-request: outstanding request abandoned; subsequent IMEM_ACK before first new request ignored.

Verification
REQ-032 Reset release, ACK one cycle after each REQ, INST_READY=1 -> INST_PC_OUT sequence 0,4,8,12 with matching words, no gaps beyond request/ack cadence.
REQ-033 INST_READY=0, ACK always -> exactly DEPTH=4 requests (0..12), FIFO_LEVEL=4, IMEM_REQ stays low; INST_READY=1 one cycle -> level 3, one new request to 16.
REQ-034 REDIRECT to 32'h0000_0103 while WAIT_ACK, ACK two cycles later -> that data dropped, FIFO empty, next request addr 32'h0000_0100.
REQ-035 REDIRECT same cycle as IMEM_ACK -> no push, next IMEM_ADDR = redirect target, FIFO_LEVEL 0.
REQ-036 HALT high 5 cycles with 2 entries and READY=1 -> level stays 2, no REQ, PC frozen; release resumes pops in order.
REQ-037 RESET_PC=32'hFFFF_FFF8, free-running -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetcher that fills a
// small prefetch FIFO of {pc, word} entries for the decode stage.

package ifu_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ifu_entry_t;
endpackage

// One prefetch FIFO slot; loads on its write strobe.
module ifu_slot
  import ifu_pkg::*;
(
  input  logic       CK_REF,
  input  logic       int_rst_n,
  input  logic       we_i,
  input  ifu_entry_t d_i,
  output ifu_entry_t q_o
);

  ifu_entry_t q_q;

  // Slot storage, cleared so the head outputs read zero out of reset.
  always_ff @(posedge CK_REF or negedge int_rst_n) begin
    if (!int_rst_n)  q_q <= '0;
    else if (we_i)   q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        CK_REF,
  input  logic        int_rst_n,
  input  logic        HALT,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic        INST_VALID,
  input  logic        INST_READY,
  output logic [31:0] INST_OUT,
  output logic [31:0] INST_PC_OUT,
  output logic [3:0]  FIFO_LEVEL
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    level_q, level_d;

  logic          issue, push, pop, nempty;
  logic [31:0]   redir_pc;
  logic          redirect_pc_unused;
  logic [DEPTH-1:0] slot_we;
  ifu_entry_t    push_entry;
  ifu_entry_t    slot_q [DEPTH];

  // Low address bits are forced to word alignment and never looked at.
  assign redir_pc           = {REDIRECT_PC[31:2], 2'b00};
  assign redirect_pc_unused = ^REDIRECT_PC[1:0];

  assign nempty = (level_q != 4'd0);

  // Only IDLE issues, so nothing is outstanding there and level < DEPTH
  // alone reserves the slot the ack will land in.
  assign issue = (state_q == S_IDLE) && !HALT && !REDIRECT && (level_q < DEPTH_L);
  // Acks keep landing under HALT: the memory side cannot be stalled.
  assign push  = (state_q == S_WAIT) && IMEM_ACK && !REDIRECT;
  assign pop   = nempty && INST_READY && !HALT && !REDIRECT;

  assign push_entry = '{pc: pc_q, word: IMEM_RDATA};

  // Fetch sequencing: one request in flight, stale responses swallowed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (issue) state_d = S_WAIT;
      S_WAIT: begin
        if (IMEM_ACK)      state_d = S_IDLE;
        else if (REDIRECT) state_d = S_DISCARD;
      end
      S_DISCARD: if (IMEM_ACK) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // PC, request and FIFO bookkeeping; a redirect flushes everything.
  always_comb begin
    pc_d     = pc_q;
    req_d    = issue;
    addr_d   = addr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (issue) addr_d = pc_q;
    if (REDIRECT) begin
      pc_d     = redir_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = 4'd0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + {3'b000, push} - {3'b000, pop};
    end
  end

  // Control state registers.
  always_ff @(posedge CK_REF or negedge int_rst_n) begin
    if (!int_rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_we[i] = push && (wr_ptr_q == AW'(i));
    ifu_slot u_slot (
      .CK_REF    (CK_REF),
      .int_rst_n (int_rst_n),
      .we_i      (slot_we[i]),
      .d_i       (push_entry),
      .q_o       (slot_q[i])
    );
  end

  assign IMEM_REQ    = req_q;
  assign IMEM_ADDR   = addr_q;
  assign INST_VALID  = nempty;
  assign INST_OUT    = slot_q[rd_ptr_q].word;
  assign INST_PC_OUT = slot_q[rd_ptr_q].pc;
  assign FIFO_LEVEL  = level_q;

endmodule
